tt_um_omarsiwy: RTL and testbench

SPI-programmed 16-channel output / PWM controller for a TinyTapeout tile. An SPI write-only peripheral on ui_in[2:0] loads five 8-bit control registers. A shared PWM generator runs at about 3 kHz from the 10 MHz tile clock. Each of the 16 outputs, on uo_out and uio_out, is individually enabled and individually switched between static-high and PWM.

---
 rtl/tt_um_omarsiwy_pkg.sv | 21 ++
 rtl/tt_um_omarsiwy_spi_peripheral.sv | 84 ++++++++
 rtl/tt_um_omarsiwy.sv | 52 +++++
 tb/tb_tt_um_omarsiwy.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_omarsiwy_pkg.sv
// Shared constants and types for the SPI-programmed 16-channel output/PWM tile.
package tt_um_omarsiwy_pkg;

   localparam int unsigned PWM_PERIOD = 3333;
   localparam int unsigned NUM_REGS   = 5;
   localparam int unsigned FRAME_W    = 16;
   localparam int unsigned CNT_W      = $clog2(PWM_PERIOD);

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   typedef struct packed {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [7:0]  duty;
   } regs_t;

endpackage

// File: rtl/tt_um_omarsiwy_spi_peripheral.sv
// Write-only SPI mode-0 peripheral: input synchronisers, edge detect, 16-bit
// frame shift and commit into the five control registers on nCS release.
module spi_peripheral
   import tt_um_omarsiwy_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  sclk,
   input  logic  copi,
   input  logic  ncs,
   output regs_t regs
);

   // [1] is the synchronised sample, [2] its previous value for edge detect
   logic [2:0]         sclk_s_q, sclk_s_d;
   logic [2:0]         ncs_s_q, ncs_s_d;
   logic [1:0]         copi_s_q, copi_s_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   regs_t              regs_q, regs_d;

   logic       sclk_rise;
   logic       ncs_fall;
   logic       ncs_rise;
   logic       wr;
   logic [6:0] addr;
   logic [7:0] data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s_q  <= '0;
         ncs_s_q   <= '1;
         copi_s_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         regs_q    <= '0;
      end else begin
         sclk_s_q  <= sclk_s_d;
         ncs_s_q   <= ncs_s_d;
         copi_s_q  <= copi_s_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         regs_q    <= regs_d;
      end
   end

   always_comb begin
      sclk_s_d  = {sclk_s_q[1:0], sclk};
      ncs_s_d   = {ncs_s_q[1:0], ncs};
      copi_s_d  = {copi_s_q[0], copi};
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      regs_d    = regs_q;

      sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
      ncs_fall  = ~ncs_s_q[1] & ncs_s_q[2];
      ncs_rise  = ncs_s_q[1] & ~ncs_s_q[2];
      wr        = shift_q[FRAME_W-1];
      addr      = shift_q[14:8];
      data      = shift_q[7:0];

      if (ncs_fall) begin
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (!ncs_s_q[1] && sclk_rise) begin
         shift_d = {shift_q[FRAME_W-2:0], copi_s_q[1]};
         // saturate so over-long frames can never alias back to 16
         if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 5'd1;
      end else if (ncs_rise && bit_cnt_q == 5'(FRAME_W) && wr
                   && 32'(addr) < NUM_REGS) begin
         case (addr)
            ADDR_EN_OUT_LO: regs_d.en_out[7:0]  = data;
            ADDR_EN_OUT_HI: regs_d.en_out[15:8] = data;
            ADDR_EN_PWM_LO: regs_d.en_pwm[7:0]  = data;
            ADDR_EN_PWM_HI: regs_d.en_pwm[15:8] = data;
            ADDR_DUTY:      regs_d.duty         = data;
            default:        regs_d              = regs_q;
         endcase
      end
   end

   assign regs = regs_q;

endmodule

// File: rtl/tt_um_omarsiwy.sv
// TinyTapeout tile top: SPI-loaded control registers, shared ~3 kHz PWM counter
// and the per-channel enable / static-or-PWM output mux.
module tt_um_omarsiwy
   import tt_um_omarsiwy_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PWM_PERIOD - 1);

   regs_t            regs;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      thresh;
   logic             pwm;
   logic [15:0]      out;
   logic             unused;

   // rst_n keeps its tile-interface name but is asserted high
   spi_peripheral u_spi (
      .clk  (clk),
      .rst  (rst_n),
      .sclk (ui_in[0]),
      .copi (ui_in[1]),
      .ncs  (ui_in[2]),
      .regs (regs)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      thresh = (32'(regs.duty) * PWM_PERIOD) >> 8;
      pwm    = (regs.duty == 8'hFF) || (32'(cnt_q) < thresh);
      out    = regs.en_out & (~regs.en_pwm | {16{pwm}});
   end

   assign uo_out  = out[7:0];
   assign uio_out = out[15:8];
   assign uio_oe  = '1;
   assign unused  = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_omarsiwy.sv
// Scoreboard bench for tt_um_omarsiwy: randomized SPI frames against a register-level model.
module tb_tt_um_omarsiwy;

   localparam int PERIOD = 3333;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       ena  = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs  = 1'b1;
   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

   assign ui_in  = {5'b0, ncs, copi, sclk};
   assign uio_in = 8'h00;

   always #50 clk = ~clk;

   tt_um_omarsiwy dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst)
   );

   typedef enum int {K_STATIC, K_HOLD, K_PWM} kind_e;
   typedef struct {
      kind_e       kind;
      logic [15:0] exp;
      logic [15:0] mask;
      int          chan;
      int          duty;
      int          id;
   } item_t;

   item_t      sb[$];
   int         checks   = 0;
   int         failures = 0;
   int         pushed   = 0;
   int         done     = 0;
   logic [7:0] mregs[5];

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
   endfunction

   function automatic void model_frame(input bit rw, input logic [6:0] addr,
                                       input logic [7:0] data, input int nbits);
      if (nbits == 16 && rw && addr < 7'd5) mregs[addr[2:0]] = data;
   endfunction

   function automatic item_t expect_item(input kind_e k, input int chan);
      item_t       it;
      logic [15:0] eo, ep;
      logic [7:0]  d;
      eo = {mregs[1], mregs[0]};
      ep = {mregs[3], mregs[2]};
      d  = mregs[4];
      it.kind = k; it.chan = chan; it.duty = int'(d); it.id = pushed;
      for (int i = 0; i < 16; i++) begin
         if (!eo[i])            begin it.exp[i] = 1'b0; it.mask[i] = 1'b1; end
         else if (!ep[i])       begin it.exp[i] = 1'b1; it.mask[i] = 1'b1; end
         else if (d == 8'h00)   begin it.exp[i] = 1'b0; it.mask[i] = 1'b1; end
         else if (d == 8'hFF)   begin it.exp[i] = 1'b1; it.mask[i] = 1'b1; end
         else                   begin it.exp[i] = 1'b0; it.mask[i] = 1'b0; end
      end
      if (k == K_PWM) it.mask[chan] = 1'b0;
      return it;
   endfunction

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input int act, input real exp, input real tol);
      real diff;
      checks++;
      diff = real'(act) - exp;
      if (diff < 0.0) diff = -diff;
      if (act < 0 || diff > tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0.1f +/- %0.1f", name, act, exp, tol);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      item_t       it;
      logic [15:0] o;
      logic        prev, cur;
      int          bad, r1, f, r2;
      forever begin
         while (sb.size() == 0) @(negedge clk);
         it = sb.pop_front();
         o  = {uio_out, uo_out};
         case (it.kind)
            K_STATIC: begin
               check($sformatf("static#%0d", it.id),
                     {8'h0, uio_oe, o & it.mask}, {8'h0, 8'hFF, it.exp & it.mask});
            end
            K_HOLD: begin
               bad = 0;
               repeat (2 * PERIOD + 20) begin
                  @(negedge clk);
                  o = {uio_out, uo_out};
                  if (((o ^ it.exp) & it.mask) != 16'h0 || uio_oe != 8'hFF) bad++;
               end
               check($sformatf("hold#%0d_bad_samples", it.id), bad, 0);
            end
            K_PWM: begin
               bad = 0; r1 = -1; f = -1; r2 = -1;
               prev = o[it.chan];
               for (int t = 1; t < 4 * PERIOD && r2 < 0; t++) begin
                  @(negedge clk);
                  o   = {uio_out, uo_out};
                  cur = o[it.chan];
                  if (((o ^ it.exp) & it.mask) != 16'h0) bad++;
                  if (!prev && cur) begin
                     if (r1 < 0) r1 = t;
                     else if (f >= 0) r2 = t;
                  end
                  if (prev && !cur && r1 >= 0 && f < 0) f = t;
                  prev = cur;
               end
               check_tol($sformatf("pwm#%0d_period", it.id),
                         (r1 >= 0 && r2 >= 0) ? r2 - r1 : -1, real'(PERIOD), PERIOD * 0.01);
               check_tol($sformatf("pwm#%0d_high_cycles", it.id),
                         (r1 >= 0 && f >= 0) ? f - r1 : -1,
                         real'(it.duty) * PERIOD / 256.0, PERIOD * 0.01);
               check($sformatf("pwm#%0d_other_bits_bad", it.id), bad, 0);
            end
            default: ;
         endcase
         done++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic push(input item_t it);
      sb.push_back(it);
      pushed++;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done != pushed && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (done != pushed) begin
         checks++;
         failures++;
         $display("FAIL monitor_timeout: done %0d expected %0d", done, pushed);
         done = pushed;
      end
   endtask

   task automatic send_bit(input logic b, input int hp);
      copi = b;
      repeat (hp) @(negedge clk);
      sclk = 1'b1;
      repeat (hp) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic spi_frame(input bit rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits);
      logic [15:0] word;
      int          hp;
      word = {rw, addr, data};
      hp   = int'($urandom_range(4, 7));
      ncs  = 1'b0;
      repeat (hp) @(negedge clk);
      for (int i = 0; i < nbits; i++)
         send_bit((i < 16) ? word[15 - i] : 1'($urandom), hp);
      repeat (hp) @(negedge clk);
      ncs = 1'b1;
      repeat (8) @(negedge clk);
      model_frame(rw, addr, data, nbits);
   endtask

   task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
      spi_frame(1'b1, addr, data, 16);
   endtask

   task automatic expect_now(input kind_e k, input int chan);
      push(expect_item(k, chan));
      wait_done();
   endtask

   initial begin : stimulus
      int          ch, nb, r;
      logic [7:0]  d;
      logic [15:0] sel, word;
      logic [6:0]  a;
      bit          rw;

      model_reset();
      repeat (5) @(negedge clk);
      expect_now(K_STATIC, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      expect_now(K_STATIC, 0);

      spi_write(7'h00, 8'hF0);
      spi_write(7'h01, 8'h01);
      expect_now(K_STATIC, 0);

      spi_frame(1'b1, 7'h30, 8'hFF, 16);
      expect_now(K_STATIC, 0);
      spi_frame(1'b0, 7'h00, 8'h0F, 16);
      expect_now(K_STATIC, 0);
      spi_frame(1'b1, 7'h00, 8'h55, 12);
      expect_now(K_STATIC, 0);
      spi_frame(1'b1, 7'h01, 8'hAA, 17);
      expect_now(K_STATIC, 0);

      spi_write(7'h00, 8'hFF);
      spi_write(7'h01, 8'hFF);
      spi_write(7'h02, 8'h01);
      spi_write(7'h03, 8'h00);
      spi_write(7'h04, 8'h80);
      expect_now(K_PWM, 0);

      spi_write(7'h04, 8'h00);
      expect_now(K_HOLD, 0);
      spi_write(7'h04, 8'hFF);
      expect_now(K_HOLD, 0);

      d   = 8'($urandom_range(1, 254));
      ch  = int'($urandom_range(0, 15));
      sel = 16'h0001 << ch;
      spi_write(7'h02, sel[7:0]);
      spi_write(7'h03, sel[15:8]);
      spi_write(7'h04, d);
      expect_now(K_PWM, ch);

      for (int k = 0; k < 30; k++) begin
         r  = int'($urandom_range(0, 9));
         a  = (r < 8) ? 7'(r) : 7'(7'h30 + r);
         rw = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0, 1, 2: nb = 16;
            3:       nb = 12;
            4:       nb = 17;
            default: nb = 15;
         endcase
         spi_frame(rw, a, 8'($urandom), nb);
         expect_now(K_STATIC, 0);
      end

      spi_write(7'h00, 8'hFF);
      spi_write(7'h01, 8'hFF);
      spi_write(7'h02, 8'h00);
      spi_write(7'h03, 8'h00);
      expect_now(K_STATIC, 0);

      word = {1'b1, 7'h02, 8'hFF};
      ncs  = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) send_bit(word[15 - i], 5);
      rst = 1'b1;
      model_reset();
      expect_now(K_STATIC, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 8; i < 16; i++) send_bit(word[15 - i], 5);
      repeat (5) @(negedge clk);
      ncs = 1'b1;
      repeat (8) @(negedge clk);
      expect_now(K_STATIC, 0);

      spi_write(7'h00, 8'h3C);
      expect_now(K_STATIC, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
